// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the IF-stage instruction
// fetch and the MEM-stage load/store path. Each access is issued in IDLE,
// waits the fixed read latency in WAIT (reads only), and completes with a
// one-cycle grant pulse in DONE. Data accesses win arbitration, but a streak
// counter forces a fetch issue after MAX_DM_STREAK back-to-back data issues
// while fetch was waiting.
//
// Parameters
//   LATENCY        memory read latency in cycles (1..15)
//   MAX_DM_STREAK  max consecutive data issues while fetch waits (1..15)
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   if_req/if_addr             fetch request (level) and byte address
//   if_gnt/if_rdata/if_stall   fetch completion pulse, fetched word, stall
//   dm_req/dm_we/dm_addr       data request, store select, byte address
//   dm_wdata/dm_wstrb          store data and byte enables
//   dm_gnt/dm_rdata/dm_stall   data completion pulse, load word, stall
//   mem_en/mem_we/mem_addr     memory access strobe, write enable, address
//   mem_wdata/mem_wstrb        memory write data and byte enables
//   mem_rdata                  memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LATENCY       = 2,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_gnt,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAT_C        = LATENCY[3:0];
  localparam logic [3:0] STREAK_MAX_C = MAX_DM_STREAK[3:0];
  localparam logic [3:0] STREAK_SAT_C = 4'hF;

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  streak_r;
  logic        owner_dm_r;
  logic        if_gnt_r;
  logic        dm_gnt_r;
  logic [31:0] if_rdata_r;
  logic [31:0] dm_rdata_r;

  logic        sel_dm_s;
  logic        issue_s;
  logic        store_s;
  logic        capture_s;

  // Arbitration: data wins unless the fetch starvation guard has tripped.
  always_comb begin
    sel_dm_s = 1'b0;
    if (dm_req && (!if_req || (streak_r != STREAK_MAX_C))) begin
      sel_dm_s = 1'b1;
    end else begin
      sel_dm_s = 1'b0;
    end
  end

  // Issue happens only in IDLE; gating with reset keeps the memory quiet
  // while reset is held even though requests may be pending.
  always_comb begin
    issue_s   = reset && (state_r == ST_IDLE) && (if_req || dm_req);
    store_s   = sel_dm_s && dm_we;
    capture_s = (state_r == ST_WAIT) && (cnt_r == LAT_C);
  end

  // Memory port: driven combinationally from the selected requester in the
  // issue cycle, all-zero otherwise (wstrb stays 0 on reads).
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_wstrb = 4'h0;
    if (issue_s) begin
      mem_en   = 1'b1;
      mem_we   = store_s;
      mem_addr = sel_dm_s ? dm_addr : if_addr;
      if (store_s) begin
        mem_wdata = dm_wdata;
        mem_wstrb = dm_wstrb;
      end else begin
        mem_wdata = 32'h0000_0000;
        mem_wstrb = 4'h0;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Access sequencer: issue, latency count, completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      owner_dm_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            owner_dm_r <= sel_dm_s;
            cnt_r      <= 4'd1;
            state_r    <= store_s ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (capture_s) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Starvation guard: counts data issues made while fetch was waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_r <= 4'd0;
    end else if (issue_s) begin
      if (sel_dm_s && if_req) begin
        streak_r <= (streak_r == STREAK_SAT_C) ? STREAK_SAT_C : streak_r + 4'd1;
      end else begin
        streak_r <= 4'd0;
      end
    end
  end

  // Grant pulses are registered so they line up with the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt_r <= 1'b0;
      dm_gnt_r <= 1'b0;
    end else begin
      if_gnt_r <= capture_s && !owner_dm_r;
      dm_gnt_r <= (capture_s && owner_dm_r) || (issue_s && store_s);
    end
  end

  // Read-data capture into the owner's holding register; stores never get here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_r <= 32'h0000_0000;
      dm_rdata_r <= 32'h0000_0000;
    end else if (capture_s) begin
      if (owner_dm_r) begin
        dm_rdata_r <= mem_rdata;
      end else begin
        if_rdata_r <= mem_rdata;
      end
    end
  end

  // Requester-side outputs.
  always_comb begin
    if_gnt   = if_gnt_r;
    dm_gnt   = dm_gnt_r;
    if_rdata = if_rdata_r;
    dm_rdata = dm_rdata_r;
    if_stall = if_req && !if_gnt_r;
    dm_stall = dm_req && !dm_gnt_r;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the IF-stage instruction fetch and the MEM-stage load/store path of the five-stage RV32I pipeline. It sequences each access (issue, fixed-latency wait, completion), returns read data to the owning requester and raises stall signals.
- Fetch stall drives the IF/ID and PC register enables low.
- Data stall freezes the pipeline behind MEM.
- Loads and stores take priority, with a starvation guard so fetch always progresses.

## Interface
- LATENCY, 2: memory read latency in cycles; `mem_rdata` is valid LATENCY cycles after the issue cycle; legal range 1..15.
- MAX_DM_STREAK, 4: maximum consecutive data-port issues while fetch is waiting; legal range 1..15.

- clk  in  1  rising-edge clock, sole clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level; held with `if_addr` stable until `if_gnt`
- if_addr  in  32  fetch byte address
- if_gnt  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  fetched word; valid with `if_gnt`, holds until next fetch completion
- if_stall  out  1  `if_req & ~if_gnt`
- dm_req  in  1  data request, level; held with all dm_* stable until `dm_gnt`
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_wstrb  in  4  store byte enables
- dm_gnt  out  1  one-cycle completion pulse for data
- dm_rdata  out  32  load word; valid with `dm_gnt`, holds until next load completion
- dm_stall  out  1  `dm_req & ~dm_gnt`
- mem_en  out  1  access strobe, exactly one cycle per access
- mem_we  out  1  write enable, qualified by `mem_en`
- mem_addr  out  32  access address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write byte enables; 0 on reads
- mem_rdata  in  32  read data from memory

## Operation
- **States:**
  - IDLE: arbitration.
  - WAIT: read in flight; latency counter runs.
  - DONE: completion cycle, no issue.
- **IDLE:**
  - If no request, `mem_en` = 0.
  - Otherwise select a requester and issue: `mem_en` = 1, mem_* driven combinationally from the selected port.
  - A selected load or fetch goes to WAIT with counter = 1.
  - A selected store goes straight to DONE.
- **Selection:**
  - Only one request pending: select it.
  - Both pending: select data, unless streak == MAX_DM_STREAK, in which case select fetch.
- **Streak counter:**
  - Data issue while `if_req` = 1: increment, saturating.
  - Data issue while `if_req` = 0, or any fetch issue: clear.
- **WAIT:**
  - Counter increments each cycle.
  - In the cycle counter == LATENCY, capture `mem_rdata` into the owner's rdata register and go to DONE.
  - LATENCY = 1: WAIT lasts one cycle.
- **DONE:**
  - Owner's gnt = 1, one cycle only.
  - No issue this cycle, so gnt never combinationally loops into a new request.
  - Next state IDLE.
- Owner, address and write fields are latched at issue; requester changes after issue do not affect the access in flight.
- Writes never update `if_rdata` or `dm_rdata`.
- No request is ever dropped. A request stays pending until it is granted.
- **Reset (asserted, or asserted mid-access):**
  - State IDLE; counter and streak 0.
  - `if_rdata` and `dm_rdata` 0.
  - `if_gnt`, `dm_gnt` and `mem_en` forced 0; all mem_* outputs 0 while reset is low.
  - Any in-flight read is abandoned; its later `mem_rdata` is ignored.
  - Stall outputs follow their requests.

## Timing
- Read issued in cycle t:
  - `mem_en` in cycle t.
  - Capture at the end of cycle t+LATENCY.
  - gnt and rdata in cycle t+LATENCY+1.
  - Earliest next issue t+LATENCY+2.
- Store issued in cycle t: gnt in cycle t+1; earliest next issue t+2.
- Request first seen in IDLE is issued in the same cycle (zero arbitration latency).
- A request arriving while busy waits in IDLE, where it is re-arbitrated.
- Stall outputs are combinational and fall in the gnt cycle.
- All state and registered outputs change only on the rising edge of `clk`, or on reset falling.

## Test plan
- **Reset:** hold reset low with `if_req` = `dm_req` = 1 → all outputs 0 except `if_stall` = `dm_stall` = 1; release → fetch/data arbitration starts in the first clock.
- **Single fetch (LATENCY = 2):**
  - Stimulus: `if_req` with `if_addr` = 0x100 in cycle 0; memory returns 0xDEADBEEF in cycle 2.
  - Required: `mem_en` high only in cycle 0 with `mem_addr` = 0x100; `if_gnt` = 1 and `if_rdata` = 0xDEADBEEF in cycle 3; `if_stall` high in cycles 0–2.
- **Simultaneous requests (LATENCY = 2):**
  - Stimulus: both requests in cycle 0, data is a load of 0x2000.
  - Required: data issued cycle 0, `dm_gnt` cycle 3; fetch issued cycle 4, `if_gnt` cycle 7; `if_rdata` unchanged through cycle 3.
- **Store:**
  - Stimulus: `dm_we` = 1, `dm_addr` = 0x40, `dm_wdata` = 0x1234ABCD, `dm_wstrb` = 0x3 in cycle 0.
  - Required: `mem_we` = 1 with matching fields in cycle 0; `dm_gnt` in cycle 1; `dm_rdata` unchanged.
- **Starvation guard:** both requests held continuously, MAX_DM_STREAK = 4 → issue order is data ×4, then fetch, then data resumes with streak cleared.
- **Reset mid-read:**
  - Stimulus: pull reset low in cycle 1 of a load, release in cycle 2.
  - Required: no `dm_gnt` for that load; with `dm_req` still high it is reissued after release, with exactly one gnt.
